// File: rtl/image_ram_arbiter_if.sv
// Bus bundle between the decoder/filter requesters, the arbiter and the image RAM.
// The arbiter uses the slave view; requesters and the RAM side use the master view.
interface image_ram_arbiter_if #(
  parameter int DATA_WIDTH    = 8,
  parameter int ADDRESS_WIDTH = 17
);
  logic                     req1, req2;
  logic                     ce1, ce2;
  logic                     we1, we2;
  logic [ADDRESS_WIDTH-1:0] addr1, addr2;
  logic [DATA_WIDTH-1:0]    wdata1, wdata2;
  logic                     gnt1, gnt2;
  logic                     rvalid1, rvalid2;
  logic [DATA_WIDTH-1:0]    rdata;
  logic                     ram_ce, ram_we;
  logic [ADDRESS_WIDTH-1:0] ram_address;
  logic [DATA_WIDTH-1:0]    ram_wdata;
  logic [DATA_WIDTH-1:0]    ram_rdata;

  modport slave (
    input  req1, req2, ce1, ce2, we1, we2, addr1, addr2, wdata1, wdata2, ram_rdata,
    output gnt1, gnt2, rvalid1, rvalid2, rdata, ram_ce, ram_we, ram_address, ram_wdata
  );

  modport master (
    output req1, req2, ce1, ce2, we1, we2, addr1, addr2, wdata1, wdata2, ram_rdata,
    input  gnt1, gnt2, rvalid1, rvalid2, rdata, ram_ce, ram_we, ram_address, ram_wdata
  );
endinterface

// File: rtl/image_ram_arbiter.sv
// Registered request/grant arbiter sharing one single-port image RAM between the
// JPEG decoder (port 1, preferred) and the filter (port 2), with a burst limit.
module image_ram_arbiter #(
  parameter int DATA_WIDTH    = 8,
  parameter int ADDRESS_WIDTH = 17,
  parameter int MAX_BURST     = 64
) (
  input  logic                clk,
  input  logic                rst,
  image_ram_arbiter_if.slave  bus
);

  localparam int CW = (MAX_BURST > 0) ? $clog2(MAX_BURST + 1) : 1;
  localparam logic [CW:0] LIMIT = (CW + 1)'(MAX_BURST);

  typedef enum logic [1:0] {IDLE, GRANT1, GRANT2} state_t;

  state_t                   state;
  logic [CW-1:0]            count;
  logic                     gnt1_q, gnt2_q;
  logic                     rvalid1_q, rvalid2_q;

  logic                     own_req, other_req, own_ce, own_we;
  logic [ADDRESS_WIDTH-1:0] own_addr;
  logic [DATA_WIDTH-1:0]    own_wdata;
  logic [CW:0]              count_inc;
  logic                     at_limit, release_now;

  always_comb begin
    own_req   = 1'b0;
    other_req = 1'b0;
    own_ce    = 1'b0;
    own_we    = 1'b0;
    own_addr  = '0;
    own_wdata = '0;
    case (state)
      GRANT1: begin
        own_req   = bus.req1;
        other_req = bus.req2;
        own_ce    = bus.ce1;
        own_we    = bus.we1;
        own_addr  = bus.addr1;
        own_wdata = bus.wdata1;
      end
      GRANT2: begin
        own_req   = bus.req2;
        other_req = bus.req1;
        own_ce    = bus.ce2;
        own_we    = bus.we2;
        own_addr  = bus.addr2;
        own_wdata = bus.wdata2;
      end
      default: ;
    endcase
    // The access in the current cycle counts toward the limit, so exactly
    // MAX_BURST accesses complete before the hand-over edge.
    count_inc   = {1'b0, count} + (CW + 1)'(own_ce);
    at_limit    = (MAX_BURST != 0) && (count_inc >= LIMIT);
    release_now = !own_req || (at_limit && other_req);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      gnt1_q    <= 1'b0;
      gnt2_q    <= 1'b0;
      rvalid1_q <= 1'b0;
      rvalid2_q <= 1'b0;
      count     <= '0;
    end else begin
      rvalid1_q <= (state == GRANT1) && bus.ce1 && !bus.we1;
      rvalid2_q <= (state == GRANT2) && bus.ce2 && !bus.we2;
      case (state)
        IDLE: begin
          count <= '0;
          if (bus.req1) begin
            state <= GRANT1; gnt1_q <= 1'b1; gnt2_q <= 1'b0;
          end else if (bus.req2) begin
            state <= GRANT2; gnt1_q <= 1'b0; gnt2_q <= 1'b1;
          end
        end
        GRANT1: begin
          if (release_now) begin
            count <= '0;
            if (bus.req2) begin
              state <= GRANT2; gnt1_q <= 1'b0; gnt2_q <= 1'b1;
            end else begin
              state <= IDLE;   gnt1_q <= 1'b0; gnt2_q <= 1'b0;
            end
          end else begin
            count <= at_limit ? LIMIT[CW-1:0] : count_inc[CW-1:0];
          end
        end
        GRANT2: begin
          if (release_now) begin
            count <= '0;
            if (bus.req1) begin
              state <= GRANT1; gnt1_q <= 1'b1; gnt2_q <= 1'b0;
            end else begin
              state <= IDLE;   gnt1_q <= 1'b0; gnt2_q <= 1'b0;
            end
          end else begin
            count <= at_limit ? LIMIT[CW-1:0] : count_inc[CW-1:0];
          end
        end
        default: begin
          state <= IDLE; gnt1_q <= 1'b0; gnt2_q <= 1'b0; count <= '0;
        end
      endcase
    end
  end

  assign bus.gnt1        = gnt1_q;
  assign bus.gnt2        = gnt2_q;
  assign bus.rvalid1     = rvalid1_q;
  assign bus.rvalid2     = rvalid2_q;
  assign bus.rdata       = bus.ram_rdata;
  assign bus.ram_ce      = own_ce;
  assign bus.ram_we      = own_we;
  assign bus.ram_address = own_addr;
  assign bus.ram_wdata   = own_wdata;

endmodule

// File: tb/tb_image_ram_arbiter.sv
// Self-checking bench for image_ram_arbiter: directed vector table plus random traffic,
// both compared against a behavioural ownership/memory model.
module tb_image_ram_arbiter;

  localparam int DW = 8;
  localparam int AW = 17;
  localparam int MB = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  image_ram_arbiter_if #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW)) bus ();

  image_ram_arbiter #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW), .MAX_BURST(MB)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Synchronous single-port RAM with deterministic initial contents.
  logic [DW-1:0] mem [0:(1<<AW)-1];
  function automatic logic [DW-1:0] init_val(input int a);
    return DW'((a * 7 + 3) & 8'hFF);
  endfunction
  initial for (int i = 0; i < (1 << AW); i++) mem[i] = init_val(i);
  always @(posedge clk) begin
    if (bus.ram_ce) begin
      if (bus.ram_we) mem[bus.ram_address] <= bus.ram_wdata;
      else            bus.ram_rdata <= mem[bus.ram_address];
    end
  end

  typedef struct {
    logic          rst, req1, req2, ce1, we1, ce2, we2;
    logic [AW-1:0] addr1, addr2;
    logic [DW-1:0] wd1, wd2;
    logic          g1, g2, rv1, rv2;
  } vec_t;

  function automatic vec_t mk(input int r, input int q1, input int q2,
                              input int c1, input int w1, input int a1, input int d1,
                              input int c2, input int w2, input int a2, input int d2,
                              input int g1, input int g2, input int v1, input int v2);
    vec_t v;
    v.rst = r[0]; v.req1 = q1[0]; v.req2 = q2[0];
    v.ce1 = c1[0]; v.we1 = w1[0]; v.addr1 = AW'(a1); v.wd1 = DW'(d1);
    v.ce2 = c2[0]; v.we2 = w2[0]; v.addr2 = AW'(a2); v.wd2 = DW'(d2);
    v.g1 = g1[0]; v.g2 = g2[0]; v.rv1 = v1[0]; v.rv2 = v2[0];
    return v;
  endfunction

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: who owns the RAM, how many accesses it made, what memory holds.
  int            m_owner = 0;
  int            m_cnt   = 0;
  bit            m_valid = 0;
  int            m_rv1 = 0, m_rv2 = 0;
  logic [DW-1:0] m_rdata = '0;
  logic [DW-1:0] ref_mem [int];

  function automatic logic [DW-1:0] ref_read(input int a);
    return ref_mem.exists(a) ? ref_mem[a] : init_val(a);
  endfunction

  task automatic model_edge(input vec_t v);
    bit c, w, q_own, q_oth;
    int a;
    logic [DW-1:0] d;
    c = 0; w = 0; a = 0; d = '0; q_own = 0; q_oth = 0;
    if (m_owner == 1) begin c = v.ce1; w = v.we1; a = int'(v.addr1); d = v.wd1; q_own = v.req1; q_oth = v.req2; end
    if (m_owner == 2) begin c = v.ce2; w = v.we2; a = int'(v.addr2); d = v.wd2; q_own = v.req2; q_oth = v.req1; end
    m_rv1 = (m_owner == 1 && c && !w) ? 1 : 0;
    m_rv2 = (m_owner == 2 && c && !w) ? 1 : 0;
    if (c && w)  ref_mem[a] = d;
    if (c && !w) m_rdata = ref_read(a);
    if (c && m_cnt < MB) m_cnt++;
    if (!v.rst) begin
      m_owner = 0; m_cnt = 0; m_rv1 = 0; m_rv2 = 0; m_valid = 1;
    end else if (m_owner == 0) begin
      m_owner = v.req1 ? 1 : (v.req2 ? 2 : 0);
      m_cnt = 0;
    end else if (!q_own || (m_cnt >= MB && q_oth)) begin
      m_owner = q_oth ? 3 - m_owner : 0;
      m_cnt = 0;
    end
  endtask

  task automatic step(input vec_t v, input bit use_tbl, input string tag);
    logic [AW-1:0] ea;
    logic [DW-1:0] ed;
    bit ec, ew;
    @(negedge clk);
    rst = v.rst;
    bus.req1 = v.req1; bus.req2 = v.req2;
    bus.ce1 = v.ce1; bus.we1 = v.we1; bus.addr1 = v.addr1; bus.wdata1 = v.wd1;
    bus.ce2 = v.ce2; bus.we2 = v.we2; bus.addr2 = v.addr2; bus.wdata2 = v.wd2;
    #1;
    if (m_valid) begin
      ec = 0; ew = 0; ea = '0; ed = '0;
      if (m_owner == 1) begin ec = v.ce1; ew = v.we1; ea = v.addr1; ed = v.wd1; end
      if (m_owner == 2) begin ec = v.ce2; ew = v.we2; ea = v.addr2; ed = v.wd2; end
      chk({tag, " ram_ce"}, 32'(bus.ram_ce), 32'(ec));
      chk({tag, " ram_we"}, 32'(bus.ram_we), 32'(ew));
      if (ec) begin
        chk({tag, " ram_address"}, 32'(bus.ram_address), 32'(ea));
        if (ew) chk({tag, " ram_wdata"}, 32'(bus.ram_wdata), 32'(ed));
      end
    end
    @(posedge clk);
    model_edge(v);
    #1;
    chk({tag, " gnt1"}, 32'(bus.gnt1), 32'(m_owner == 1));
    chk({tag, " gnt2"}, 32'(bus.gnt2), 32'(m_owner == 2));
    chk({tag, " rvalid1"}, 32'(bus.rvalid1), 32'(m_rv1));
    chk({tag, " rvalid2"}, 32'(bus.rvalid2), 32'(m_rv2));
    if (m_rv1 != 0 || m_rv2 != 0) chk({tag, " rdata"}, 32'(bus.rdata), 32'(m_rdata));
    if (use_tbl) begin
      chk({tag, " tbl gnt1"}, 32'(bus.gnt1), 32'(v.g1));
      chk({tag, " tbl gnt2"}, 32'(bus.gnt2), 32'(v.g2));
      chk({tag, " tbl rvalid1"}, 32'(bus.rvalid1), 32'(v.rv1));
      chk({tag, " tbl rvalid2"}, 32'(bus.rvalid2), 32'(v.rv2));
    end
  endtask

  vec_t tbl[$];
  int   p1_writes;

  initial begin
    bus.req1 = 0; bus.req2 = 0; bus.ce1 = 0; bus.ce2 = 0; bus.we1 = 0; bus.we2 = 0;
    bus.addr1 = '0; bus.addr2 = '0; bus.wdata1 = '0; bus.wdata2 = '0;

    //          rst q1 q2  c1 w1 a1     d1     c2 w2 a2     d2     g1 g2 v1 v2
    tbl.push_back(mk(0, 1, 1,  0, 0, 0,     0,     0, 0, 0,     0,     0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 1,  1, 1, 'h10,  'hA0,  0, 0, 0,     0,     0, 0, 0, 0));
    tbl.push_back(mk(1, 1, 1,  0, 0, 0,     0,     0, 0, 0,     0,     1, 0, 0, 0));
    tbl.push_back(mk(1, 1, 1,  1, 1, 'h10,  'hA1,  0, 0, 0,     0,     1, 0, 0, 0));
    tbl.push_back(mk(1, 1, 1,  1, 1, 'h11,  'hA2,  0, 0, 0,     0,     1, 0, 0, 0));
    tbl.push_back(mk(1, 1, 1,  1, 1, 'h12,  'hA3,  0, 0, 0,     0,     1, 0, 0, 0));
    tbl.push_back(mk(1, 1, 1,  1, 1, 'h13,  'hA4,  0, 0, 0,     0,     0, 1, 0, 0));
    tbl.push_back(mk(1, 1, 1,  1, 1, 'h14,  'hA5,  0, 0, 0,     0,     0, 1, 0, 0));
    tbl.push_back(mk(1, 1, 1,  0, 0, 0,     0,     1, 0, 'h123, 0,     0, 1, 0, 1));
    tbl.push_back(mk(1, 1, 1,  1, 1, 'h123, 'hEE,  1, 1, 'h124, 'h77,  0, 1, 0, 0));
    tbl.push_back(mk(1, 1, 1,  0, 0, 0,     0,     1, 0, 'h123, 0,     0, 1, 0, 1));
    tbl.push_back(mk(1, 1, 0,  0, 0, 0,     0,     0, 0, 0,     0,     1, 0, 0, 0));
    tbl.push_back(mk(1, 1, 0,  1, 0, 'h124, 0,     0, 0, 0,     0,     1, 0, 1, 0));
    tbl.push_back(mk(1, 1, 0,  1, 0, 'h10,  0,     0, 0, 0,     0,     1, 0, 1, 0));
    tbl.push_back(mk(0, 1, 0,  1, 0, 'h11,  0,     0, 0, 0,     0,     0, 0, 0, 0));
    tbl.push_back(mk(1, 0, 0,  0, 0, 0,     0,     0, 0, 0,     0,     0, 0, 0, 0));
    tbl.push_back(mk(1, 0, 1,  0, 0, 0,     0,     0, 0, 0,     0,     0, 1, 0, 0));
    for (int i = 0; i < 6; i++)
      tbl.push_back(mk(1, 0, 1, 0, 0, 0, 0, 1, 1, 'h40 + i, i, 0, 1, 0, 0));
    tbl.push_back(mk(1, 1, 1,  0, 0, 0,     0,     0, 0, 0,     0,     1, 0, 0, 0));
    tbl.push_back(mk(1, 0, 1,  0, 0, 0,     0,     0, 0, 0,     0,     0, 1, 0, 0));
    tbl.push_back(mk(1, 0, 0,  0, 0, 0,     0,     0, 0, 0,     0,     0, 0, 0, 0));

    p1_writes = 0;
    foreach (tbl[i]) begin
      step(tbl[i], 1'b1, $sformatf("vec%0d", i));
      if (i >= 3 && i <= 7 && bus.gnt1 == 1'b0 && i == 7) p1_writes = p1_writes;
    end

    // Burst-limit write count from port 1 read back through memory: 0x10..0x13 written, 0x14 not.
    chk("burst mem 0x13", 32'(mem[17'h13]), 32'h00A4);
    chk("burst mem 0x14", 32'(mem[17'h14]), 32'(init_val('h14)));
    chk("isolation mem 0x123", 32'(mem[17'h123]), 32'(init_val('h123)));
    chk("port2 write 0x124", 32'(mem[17'h124]), 32'h0077);

    begin
      vec_t v;
      bit r1, r2;
      r1 = 0; r2 = 0;
      for (int n = 0; n < 1500; n++) begin
        if ($urandom_range(0, 7) == 0) r1 = ~r1;
        if ($urandom_range(0, 5) == 0) r2 = ~r2;
        v = mk(($urandom_range(0, 63) != 0) ? 1 : 0, int'(r1), int'(r2),
               int'($urandom_range(0, 1)), int'($urandom_range(0, 1)), int'($urandom_range(0, 15)),
               int'($urandom_range(0, 255)),
               int'($urandom_range(0, 1)), int'($urandom_range(0, 1)), int'($urandom_range(0, 15)),
               int'($urandom_range(0, 255)),
               0, 0, 0, 0);
        step(v, 1'b0, $sformatf("rnd%0d", n));
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
